// File: rtl/com_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | com_frame_sequencer                                                      |
// | Turns a masked raster stream into center_of_mass input, then tabulates  |
// | and latches the centroid with found/timeout handling.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module com_frame_sequencer #(
    parameter int H_ACTIVE       = 1280,
    parameter int V_ACTIVE       = 720,
    parameter int MIN_PIXELS     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pixel_valid_in,
    input  logic        mask_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        tabulate_out,
    input  logic [10:0] com_x_in,
    input  logic [9:0]  com_y_in,
    input  logic        com_valid_in,
    output logic [10:0] centroid_x_out,
    output logic [9:0]  centroid_y_out,
    output logic        centroid_valid_out,
    output logic        found_out,
    output logic        error_out,
    output logic        busy_out
);

    localparam int              c_tw      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_tw-1:0] c_to_last = c_tw'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0]     c_h_last  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]      c_v_last  = 10'(V_ACTIVE - 1);
    localparam logic [20:0]     c_min_pix = 21'(MIN_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STREAM   = 2'd1,
        S_TABULATE = 2'd2,
        S_WAIT     = 2'd3
    } state_t;

    state_t          r_state, w_state_next;
    logic [20:0]     r_pix_count, w_pix_count_next;
    logic [c_tw-1:0] r_to_count, w_to_count_next;
    logic [10:0]     r_x, w_x_next, r_cx, w_cx_next;
    logic [9:0]      r_y, w_y_next, r_cy, w_cy_next;
    logic            r_valid, w_valid_next;
    logic            r_tab, w_tab_next;
    logic            r_cvalid, w_cvalid_next;
    logic            r_found, w_found_next;
    logic            r_error, w_error_next;

    logic        w_is_origin, w_is_last, w_in_range;
    logic        w_start, w_truncate, w_stream, w_fwd, w_frame_end, w_enough;
    logic [20:0] w_count_base, w_count_upd;

    // The starting (0,0) pixel is handled as a stream pixel on the same cycle;
    // a (0,0) seen while already streaming marks a truncated frame instead.
    assign w_is_origin  = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign w_is_last    = pixel_valid_in && (hcount_in == c_h_last) && (vcount_in == c_v_last);
    assign w_in_range   = (hcount_in <= c_h_last) && (vcount_in <= c_v_last);
    assign w_start      = (r_state == S_IDLE) && w_is_origin;
    assign w_truncate   = (r_state == S_STREAM) && w_is_origin;
    assign w_stream     = w_start || ((r_state == S_STREAM) && !w_is_origin);
    assign w_count_base = w_start ? '0 : r_pix_count;
    assign w_fwd        = w_stream && pixel_valid_in && mask_in && w_in_range;
    assign w_count_upd  = (w_fwd && (w_count_base != '1)) ? w_count_base + 21'd1 : w_count_base;
    assign w_frame_end  = w_truncate || (w_stream && w_is_last);
    assign w_enough     = (w_count_upd >= c_min_pix);

    always_comb begin
        w_state_next     = r_state;
        w_pix_count_next = r_pix_count;
        w_to_count_next  = r_to_count;
        w_x_next         = r_x;
        w_y_next         = r_y;
        w_cx_next        = r_cx;
        w_cy_next        = r_cy;
        w_valid_next     = 1'b0;
        w_tab_next       = 1'b0;
        w_cvalid_next    = 1'b0;
        w_found_next     = r_found;
        w_error_next     = r_error;

        case (r_state)
            S_IDLE, S_STREAM: begin
                if (w_stream) begin
                    w_state_next     = S_STREAM;
                    w_pix_count_next = w_count_upd;
                end
                if (w_fwd) begin
                    w_x_next     = hcount_in;
                    w_y_next     = vcount_in;
                    w_valid_next = 1'b1;
                end
                if (w_truncate) begin
                    w_error_next = 1'b1;
                end
                if (w_frame_end) begin
                    if (w_enough) begin
                        w_state_next = S_TABULATE;
                    end else begin
                        w_state_next  = S_IDLE;
                        w_cvalid_next = 1'b1;
                        w_found_next  = 1'b0;
                    end
                end
            end
            S_TABULATE: begin
                w_tab_next      = 1'b1;
                w_to_count_next = '0;
                w_state_next    = S_WAIT;
            end
            S_WAIT: begin
                // A result on the final timeout cycle still counts as found.
                if (com_valid_in) begin
                    w_cx_next     = com_x_in;
                    w_cy_next     = com_y_in;
                    w_cvalid_next = 1'b1;
                    w_found_next  = 1'b1;
                    w_state_next  = S_IDLE;
                end else if (r_to_count == c_to_last) begin
                    w_cvalid_next = 1'b1;
                    w_found_next  = 1'b0;
                    w_error_next  = 1'b1;
                    w_state_next  = S_IDLE;
                end else begin
                    w_to_count_next = r_to_count + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_pix_count <= '0;
            r_to_count  <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_valid     <= 1'b0;
            r_tab       <= 1'b0;
            r_cvalid    <= 1'b0;
            r_found     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pix_count <= w_pix_count_next;
            r_to_count  <= w_to_count_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_cx        <= w_cx_next;
            r_cy        <= w_cy_next;
            r_valid     <= w_valid_next;
            r_tab       <= w_tab_next;
            r_cvalid    <= w_cvalid_next;
            r_found     <= w_found_next;
            r_error     <= w_error_next;
        end
    end

    assign x_out              = r_x;
    assign y_out              = r_y;
    assign valid_out          = r_valid;
    assign tabulate_out       = r_tab;
    assign centroid_x_out     = r_cx;
    assign centroid_y_out     = r_cy;
    assign centroid_valid_out = r_cvalid;
    assign found_out          = r_found;
    assign error_out          = r_error;
    assign busy_out           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_com_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_com_frame_sequencer                                                   |
// | Directed frames with a queue scoreboard checked by a negedge monitor.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_com_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        pixel_valid = 1'b0;
    logic        mask = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        tabulate_out;
    logic [10:0] com_x = '0;
    logic [9:0]  com_y = '0;
    logic        com_valid = 1'b0;
    logic [10:0] centroid_x;
    logic [9:0]  centroid_y;
    logic        centroid_valid;
    logic        found;
    logic        error;
    logic        busy;

    com_frame_sequencer #(
        .H_ACTIVE(8), .V_ACTIVE(4), .MIN_PIXELS(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .hcount_in(hcount), .vcount_in(vcount),
        .pixel_valid_in(pixel_valid), .mask_in(mask),
        .x_out(x_out), .y_out(y_out), .valid_out(valid_out),
        .tabulate_out(tabulate_out),
        .com_x_in(com_x), .com_y_in(com_y), .com_valid_in(com_valid),
        .centroid_x_out(centroid_x), .centroid_y_out(centroid_y),
        .centroid_valid_out(centroid_valid), .found_out(found),
        .error_out(error), .busy_out(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int a; int b; } ev_t;
    typedef struct { int c; int f; int cx; int cy; int e; } cv_t;

    ev_t fwd_q[$];
    int  tab_q[$];
    cv_t cv_q[$];

    int checks = 0;
    int errors = 0;
    int last_cyc = 0;
    logic [7:0] mrow [4];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of its queue.
    ev_t m_e;
    cv_t m_c;
    int  m_t;
    always @(negedge clk) begin
        if (valid_out) begin
            if (fwd_q.size() == 0) cmp("unexpected valid_out", 1, 0);
            else begin
                m_e = fwd_q.pop_front();
                cmp("valid_out cycle", cyc, m_e.c);
                cmp("x_out", 32'(x_out), m_e.a);
                cmp("y_out", 32'(y_out), m_e.b);
                cmp("no tabulate with valid_out", 32'(tabulate_out), 0);
            end
        end
        if (tabulate_out) begin
            if (tab_q.size() == 0) cmp("unexpected tabulate_out", 1, 0);
            else begin
                m_t = tab_q.pop_front();
                cmp("tabulate_out cycle", cyc, m_t);
            end
        end
        if (centroid_valid) begin
            if (cv_q.size() == 0) cmp("unexpected centroid_valid_out", 1, 0);
            else begin
                m_c = cv_q.pop_front();
                cmp("centroid_valid cycle", cyc, m_c.c);
                cmp("found_out", 32'(found), m_c.f);
                cmp("centroid_x_out", 32'(centroid_x), m_c.cx);
                cmp("centroid_y_out", 32'(centroid_y), m_c.cy);
                cmp("error_out at pulse", 32'(error), m_c.e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pix(input int h, input int v, input bit m, input bit exp_fwd);
        hcount      = 11'(h);
        vcount      = 10'(v);
        pixel_valid = 1'b1;
        mask        = m;
        if (exp_fwd) fwd_q.push_back('{cyc + 1, h, v});
        last_cyc = cyc;
        tick();
        pixel_valid = 1'b0;
        mask        = 1'b0;
    endtask

    task automatic set_mask(input int h, input int v);
        mrow[v][h] = 1'b1;
    endtask

    task automatic clear_masks();
        for (int r = 0; r < 4; r++) mrow[r] = '0;
    endtask

    // Raster pixels 0..stop_at-1; optional out-of-range masked pixels before inject_at.
    task automatic frame(input int stop_at, input int inject_at);
        for (int i = 0; i < 32; i++) begin
            if (i == stop_at) return;
            if (i == inject_at) begin
                pix(9, i / 8, 1'b1, 1'b0);
                pix(i % 8, 5, 1'b1, 1'b0);
            end
            pix(i % 8, i / 8, mrow[i / 8][i % 8], mrow[i / 8][i % 8]);
        end
    endtask

    task automatic send_result(input int x, input int y);
        com_x     = 11'(x);
        com_y     = 10'(y);
        com_valid = 1'b1;
        tick();
        com_valid = 1'b0;
    endtask

    task automatic scenario1();
        int n;
        clear_masks();
        set_mask(2, 1); set_mask(4, 1); set_mask(6, 3);
        frame(32, -1);
        n = last_cyc;
        tab_q.push_back(n + 2);
        wait_until(n + 5);
        cv_q.push_back('{n + 6, 1, 4, 2, 0});
        send_result(4, 2);
        repeat (3) tick();
    endtask

    initial begin
        int n;
        clear_masks();
        tick(); tick();
        cmp("reset busy_out", 32'(busy), 0);
        cmp("reset error_out", 32'(error), 0);
        cmp("reset outputs", {valid_out, tabulate_out, centroid_valid, found, x_out, y_out}, 0);
        rst = 1'b0;
        tick();

        // 1: normal frame, result returned 3 cycles after tabulate.
        scenario1();

        // 2: one in-range masked pixel plus masked out-of-range pixels: not found.
        clear_masks();
        set_mask(3, 2);
        frame(32, 10);
        n = last_cyc;
        cv_q.push_back('{n + 1, 0, 4, 2, 0});
        repeat (4) tick();
        cmp("busy after not-found", 32'(busy), 0);

        // 3: timeout in WAIT.
        clear_masks();
        set_mask(1, 0); set_mask(5, 1); set_mask(2, 2); set_mask(7, 3);
        frame(32, -1);
        n = last_cyc;
        tab_q.push_back(n + 2);
        cv_q.push_back('{n + 18, 0, 4, 2, 1});
        wait_until(n + 17);
        cmp("busy during wait", 32'(busy), 1);
        cmp("error before timeout", 32'(error), 0);
        wait_until(n + 18);
        cmp("busy after timeout", 32'(busy), 0);
        cmp("error after timeout", 32'(error), 1);
        repeat (2) tick();

        // Clock-aligned reset clears sticky error and the centroid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("error cleared by reset", 32'(error), 0);
        cmp("centroid cleared by reset", {21'd0, centroid_x, centroid_y}, 0);
        tick();

        // 5: out-of-range pixels and stray com_valid while IDLE.
        pix(9, 0, 1'b1, 1'b0);
        pix(0, 5, 1'b1, 1'b0);
        pix(9, 5, 1'b1, 1'b0);
        send_result(5, 3);
        tick();
        cmp("idle busy after strays", 32'(busy), 0);
        cmp("idle centroid after strays", {21'd0, centroid_x, centroid_y}, 0);

        // 4: truncated frame, (0,0) during WAIT ignored.
        clear_masks();
        set_mask(1, 0); set_mask(3, 0); set_mask(5, 1);
        frame(14, -1);
        pix(0, 0, 1'b1, 1'b0);
        n = last_cyc;
        tab_q.push_back(n + 2);
        cmp("error after truncation", 32'(error), 1);
        pix(0, 0, 1'b1, 1'b0);
        pix(0, 0, 1'b1, 1'b0);
        pix(0, 0, 1'b1, 1'b0);
        cmp("busy while waiting", 32'(busy), 1);
        wait_until(n + 5);
        cv_q.push_back('{n + 6, 1, 3, 1, 1});
        send_result(3, 1);
        cmp("busy after result", 32'(busy), 0);
        repeat (3) tick();

        // 6: asynchronous reset mid-stream, then a clean frame.
        clear_masks();
        set_mask(1, 0); set_mask(2, 0);
        frame(3, -1);
        tick();
        #2 rst = 1'b1;
        #1;
        cmp("async reset x_out", 32'(x_out), 0);
        cmp("async reset busy", 32'(busy), 0);
        cmp("async reset error", 32'(error), 0);
        cmp("async reset others", {valid_out, tabulate_out, centroid_valid, found, centroid_x, centroid_y}, 0);
        #1 rst = 1'b0;
        tick();
        scenario1();

        repeat (5) tick();
        cmp("pending valid_out events", fwd_q.size(), 0);
        cmp("pending tabulate events", tab_q.size(), 0);
        cmp("pending centroid events", cv_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/com_frame_sequencer.md
# com_frame_sequencer

Frame-level driver for `center_of_mass`. It converts the camera's raster stream plus a per-pixel mask bit into the sparse coordinate stream that `center_of_mass` consumes. At frame end it issues the tabulate pulse and waits for the centroid result, applying a timeout. It then presents the latched centroid, with a found/not-found flag, to downstream gesture logic.

## Interface
Parameters:
- `H_ACTIVE`, 1280: active pixels per line.
- `V_ACTIVE`, 720: active lines per frame.
- `MIN_PIXELS`, 64: minimum masked pixels per frame for a valid centroid.
- `TIMEOUT_CYCLES`, 4096: maximum wait in WAIT for the centroid result.

Ports:
- `clk_in` in 1: single system clock.
- `rst_in` in 1: reset, asynchronous and active-high.
- `hcount_in` in 11: raster x of the current pixel.
- `vcount_in` in 10: raster y of the current pixel.
- `pixel_valid_in` in 1: pixel strobe; the coordinates are meaningful only when high.
- `mask_in` in 1: pixel belongs to the tracked object.
- `x_out` out 11: forwarded x, to `center_of_mass` `x_in`.
- `y_out` out 10: forwarded y, to `center_of_mass` `y_in`.
- `valid_out` out 1: forwarded pixel strobe.
- `tabulate_out` out 1: one-cycle pulse requesting the centroid.
- `com_x_in` in 11, `com_y_in` in 10, `com_valid_in` in 1: result from `center_of_mass`.
- `centroid_x_out` out 11, `centroid_y_out` out 10: latched centroid.
- `centroid_valid_out` out 1: one-cycle pulse, once per frame outcome.
- `found_out` out 1: qualifies the current frame outcome; 1 means the centroid is fresh.
- `error_out` out 1: sticky; set on timeout or truncated frame; cleared only by reset.
- `busy_out` out 1: high in every state except IDLE.

## Operation
- States: IDLE, STREAM, TABULATE, WAIT.
- Reset, asynchronous: state=IDLE, pixel count=0, timeout count=0. Every output is 0, including the centroid registers.
- IDLE: a strobed pixel at (0,0) enters STREAM. That pixel is processed as a STREAM pixel on the same cycle. All other pixels are ignored.
- STREAM, forwarding a pixel:
  - Forward when `pixel_valid_in & mask_in & hcount_in<H_ACTIVE & vcount_in<V_ACTIVE`.
  - Register `x_out`/`y_out` and assert `valid_out` for one cycle.
  - Increment the pixel count (21 bits, saturating at all-ones).
  - Out-of-range coordinates are never forwarded and never counted.
- STREAM, frame end: a strobed pixel at (H_ACTIVE-1, V_ACTIVE-1) is processed normally, then:
  - count ≥ MIN_PIXELS (the count includes this pixel): go to TABULATE.
  - Otherwise: go to IDLE and pulse `centroid_valid_out` with `found_out`=0. The centroid registers hold their previous values.
- STREAM, truncated frame: a strobed pixel at (0,0) while in STREAM.
  - That pixel is dropped and `error_out` is set.
  - The count check above is then applied exactly as for a normal frame end.
- TABULATE: `tabulate_out`=1 for exactly one cycle, then go to WAIT with the timeout count cleared.
- WAIT, result arrives: on `com_valid_in`, latch `com_x_in`/`com_y_in` into `centroid_x_out`/`centroid_y_out`. Pulse `centroid_valid_out`, set `found_out`=1, go to IDLE.
- WAIT, no result: the timeout count increments each cycle. When it reaches TIMEOUT_CYCLES-1 without `com_valid_in`:
  - pulse `centroid_valid_out` with `found_out`=0;
  - set `error_out`;
  - go to IDLE.
- WAIT, simultaneous events: `com_valid_in` on the final timeout cycle wins, so the result is found and no error is flagged.
- `com_valid_in` outside WAIT is ignored.
- Pixels arriving in TABULATE or WAIT are dropped. A (0,0) pixel arriving then is missed, so the next frame is skipped.
- Pixel count is cleared on every entry to STREAM.
- `found_out` changes only together with a `centroid_valid_out` pulse and holds its value between pulses.

## Timing
- `valid_out`/`x_out`/`y_out`: registered, 1 cycle after the input pixel. `x_out`/`y_out` hold their last values when `valid_out`=0.
- `tabulate_out`: asserted 2 cycles after the last-pixel input, i.e. the cycle after its `valid_out`. Never asserted in the same cycle as `valid_out`.
- Centroid outputs: update 1 cycle after `com_valid_in` is sampled.
- Not-found pulse at frame end: 1 cycle after the last-pixel input.
- Timeout pulse: TIMEOUT_CYCLES cycles after WAIT entry.
- Reset asserted mid-frame or in WAIT: immediate return to IDLE with all outputs 0. The first frame after reset must start at (0,0).

## Test plan
Parameters for all scenarios: H_ACTIVE=8, V_ACTIVE=4, MIN_PIXELS=2, TIMEOUT_CYCLES=16.
1. Full frame, mask set at (2,1), (4,1), (6,3); `com_valid_in` with (4,2) returned 3 cycles after `tabulate_out`:
   - three `valid_out` pulses with matching coordinates, each 1 cycle after its input;
   - `tabulate_out` 2 cycles after (7,3);
   - centroid (4,2), `found_out`=1, `error_out`=0.
2. Frame with only (3,2) masked → no `tabulate_out`; `centroid_valid_out` pulse with `found_out`=0 1 cycle after (7,3); centroid holds (4,2) from scenario 1.
3. Frame with 4 masked pixels, `com_valid_in` never driven → `centroid_valid_out` 16 cycles after WAIT entry, `found_out`=0, `error_out`=1, `busy_out` low afterwards.
4. Frame restarted at (0,0) after 3 masked pixels:
   - restart pixel not forwarded;
   - `error_out`=1;
   - `tabulate_out` pulse;
   - (0,0) pixels arriving during WAIT ignored until the result is returned.
5. Pixels at hcount=9 and vcount=5 with mask set, plus `com_valid_in` pulsed while IDLE → no `valid_out`, no state change.
6. Reset asserted during STREAM after 2 forwarded pixels → all outputs 0 asynchronously; the next full frame behaves exactly as scenario 1.
